// File: rtl/cv_bg_tile_fetch.sv
// cv_bg_tile_fetch: per-scanline BG tile-map fetch sequencer feeding a 2-entry skid FIFO.
// Optional sticky line_start-while-busy flag enabled by CV_BG_FETCH_OVERRUN_EN.
module cv_bg_tile_fetch #(
   parameter int TILES  = 33,
   parameter int LINE_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              line_start,
   input  logic [LINE_W-1:0] line,
   input  logic [9:0]        r_xoffset,
   input  logic [9:0]        r_yoffset,
   output logic [13:0]       t_addr,
   output logic              t_ren,
   input  logic [9:0]        t_dout,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [9:0]        o_tile,
   output logic              o_last,
   output logic [2:0]        o_fine_x,
   output logic [2:0]        o_fine_y,
   output logic              busy,
   output logic              o_overrun
);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   state_t      state;
   logic [9:0]  xs, ys, ys_next;
   logic [6:0]  c;
   logic        inflight, inflight_last, pop, last_col, rd_ptr, wr_ptr;
   logic [1:0]  count;
   logic [2:0]  occ;
   logic [10:0] mem [2];
   assign ys_next  = 10'(line) + r_yoffset;
   assign o_valid  = count != 2'd0;
   assign pop      = o_valid & o_ready;
   // occupancy as it will stand after this cycle's pop and the pending capture
   assign occ      = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
   assign t_ren    = state == FETCH && occ < 3'd2;
   assign last_col = c == 7'(TILES - 1);
   assign t_addr   = {ys[9:3], 7'(xs[9:3] + c)};
   assign o_tile   = mem[rd_ptr][9:0];
   assign o_last   = mem[rd_ptr][10];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         xs            <= '0;
         ys            <= '0;
         c             <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         count         <= '0;
         busy          <= 1'b0;
         o_fine_x      <= '0;
         o_fine_y      <= '0;
         mem[0]        <= '0;
         mem[1]        <= '0;
      end else if (line_start) begin
         state    <= FETCH;
         xs       <= r_xoffset;
         ys       <= ys_next;
         c        <= '0;
         inflight <= 1'b0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         count    <= '0;
         busy     <= 1'b1;
         o_fine_x <= r_xoffset[2:0];
         o_fine_y <= ys_next[2:0];
      end else begin
         inflight      <= t_ren;
         inflight_last <= last_col;
         count         <= occ[1:0];
         if (t_ren) begin
            c <= c + 7'd1;
            if (last_col) state <= DRAIN;
         end
         if (inflight) begin
            mem[wr_ptr] <= {inflight_last, t_dout};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         if (state == DRAIN && !inflight && occ == 3'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end
`ifdef CV_BG_FETCH_OVERRUN_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) o_overrun <= 1'b0;
      else if (line_start && busy) o_overrun <= 1'b1;
   end
`else
   assign o_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_cv_bg_tile_fetch.sv
// tb_cv_bg_tile_fetch: directed scoreboard bench for cv_bg_tile_fetch (TILES=33 and TILES=1 instances).
module tb_cv_bg_tile_fetch;
   localparam int T = 33;
   logic        clk = 0, reset = 1, line_start = 0, o_ready = 0;
   logic [8:0]  line = '0;
   logic [9:0]  r_xoffset = '0, r_yoffset = '0, t_dout = '0, t_dout1 = '0;
   logic [13:0] t_addr, t_addr1;
   logic [9:0]  o_tile, o_tile1;
   logic [2:0]  o_fine_x, o_fine_y, o_fine_x1, o_fine_y1;
   logic        t_ren, o_valid, o_last, busy, o_overrun;
   logic        t_ren1, o_valid1, o_last1, busy1, o_overrun1;
   int          n_checks = 0, n_fail = 0, popped = 0, tb_cnt = 0, tb_infl = 0;
   bit          chk_occ = 0;
   logic [10:0] exp_q[$];

   cv_bg_tile_fetch #(.TILES(T), .LINE_W(9)) dut (
      .clk(clk), .reset(reset), .line_start(line_start), .line(line),
      .r_xoffset(r_xoffset), .r_yoffset(r_yoffset), .t_addr(t_addr), .t_ren(t_ren),
      .t_dout(t_dout), .o_valid(o_valid), .o_ready(o_ready), .o_tile(o_tile),
      .o_last(o_last), .o_fine_x(o_fine_x), .o_fine_y(o_fine_y), .busy(busy),
      .o_overrun(o_overrun));

   cv_bg_tile_fetch #(.TILES(1), .LINE_W(9)) dut1 (
      .clk(clk), .reset(reset), .line_start(line_start), .line(line),
      .r_xoffset(r_xoffset), .r_yoffset(r_yoffset), .t_addr(t_addr1), .t_ren(t_ren1),
      .t_dout(t_dout1), .o_valid(o_valid1), .o_ready(o_ready), .o_tile(o_tile1),
      .o_last(o_last1), .o_fine_x(o_fine_x1), .o_fine_y(o_fine_y1), .busy(busy1),
      .o_overrun(o_overrun1));

   always #5 clk = ~clk;

   function automatic logic [9:0] tval(logic [13:0] a);
      return a[9:0] ^ {a[13:7], 3'b101};
   endfunction

   function automatic logic [13:0] addr_of(int l, logic [9:0] xo, logic [9:0] yo, int i);
      logic [9:0] ys;
      logic [6:0] col;
      ys  = 10'(l) + yo;
      col = xo[9:3] + 7'(i);
      return {ys[9:3], col};
   endfunction

   // tile memory model: one-cycle read latency, junk when not enabled
   always @(posedge clk) begin
      t_dout  <= t_ren  ? tval(t_addr)  : 10'h2AA;
      t_dout1 <= t_ren1 ? tval(t_addr1) : 10'h2AA;
   end

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      int occ;
      logic [10:0] e;
      if (!reset && o_valid && o_ready) begin
         if (exp_q.size() == 0) check("word_underflow", 0, 1);
         else begin
            e = exp_q.pop_front();
            check("word", {o_last, o_tile}, e);
         end
         popped++;
      end
      if (chk_occ) begin
         if (line_start) begin
            tb_cnt  = 0;
            tb_infl = 0;
         end else begin
            occ = tb_cnt + tb_infl - ((o_valid && o_ready) ? 1 : 0);
            if (t_ren) check("issue_occ_lt2", occ < 2, 1);
            tb_cnt  = occ;
            tb_infl = t_ren ? 1 : 0;
         end
      end
   end

   task automatic start_line(int l, logic [9:0] xo, logic [9:0] yo);
      line = 9'(l); r_xoffset = xo; r_yoffset = yo; line_start = 1;
      exp_q.delete();
      popped = 0;
      for (int i = 0; i < T; i++) exp_q.push_back({i == T - 1, tval(addr_of(l, xo, yo, i))});
      @(posedge clk); #1 line_start = 0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 3000 && busy; n++) begin
         @(posedge clk); #1;
      end
      check("idle_timeout", busy, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_t_addr", t_addr, 0);
      check("rst_t_ren", t_ren, 0);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_tile", o_tile, 0);
      check("rst_o_last", o_last, 0);
      check("rst_fine_x", o_fine_x, 0);
      check("rst_fine_y", o_fine_y, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", o_overrun, 0);
      @(posedge clk); #1 reset = 0;

      // plain line, ready always high
      o_ready = 1;
      start_line(5, 10'h000, 10'h000);
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         check("t1_t_ren", t_ren, k <= T);
         if (k <= T) check("t1_t_addr", t_addr, k - 1);
         check("t1_o_valid", o_valid, k >= 3 && k <= T + 2);
         check("t1_busy", busy, k <= T + 2);
         @(posedge clk); #1;
      end
      check("t1_fine_x", o_fine_x, 0);
      check("t1_fine_y", o_fine_y, 5);
      check("t1_words", popped, T);
      check("t1_q_empty", exp_q.size(), 0);

      // X wrap at 128 tiles, Y wrap at 1024
      start_line(6, 10'h3F9, 10'h3FC);
      for (int k = 1; k <= T; k++) begin
         @(negedge clk);
         if (k == 1) check("t2_addr_first", t_addr, 14'h07F);
         if (k == 2) check("t2_addr_second", t_addr, 14'h000);
         check("t2_t_addr", t_addr, addr_of(6, 10'h3F9, 10'h3FC, k - 1));
         @(posedge clk); #1;
      end
      check("t2_fine_x", o_fine_x, 1);
      check("t2_fine_y", o_fine_y, 2);
      wait_idle();
      check("t2_words", popped, T);

      // random backpressure
      chk_occ = 1;
      o_ready = 0;
      start_line(100, 10'h123, 10'h2A7);
      for (int n = 0; n < 3000 && busy; n++) begin
         o_ready = $urandom_range(0, 9) < 3;
         @(posedge clk); #1;
      end
      check("t3_idle", busy, 0);
      check("t3_words", popped, T);
      check("t3_q_empty", exp_q.size(), 0);
      chk_occ = 0;

      // abort at word 10
      o_ready = 1;
      start_line(20, 10'h010, 10'h000);
      for (int n = 0; n < 200 && popped < 10; n++) begin
         @(posedge clk); #1;
      end
      check("t4_reach_word10", popped, 10);
      o_ready = 0;
      start_line(3, 10'h048, 10'h008);
      @(negedge clk);
      check("t4_restart_addr", t_addr, addr_of(3, 10'h048, 10'h008, 0));
      @(posedge clk); #1 o_ready = 1;
      wait_idle();
      check("t4_words", popped, T);
      check("t4_q_empty", exp_q.size(), 0);
      check("t4_fine_x", o_fine_x, 0);
      check("t4_fine_y", o_fine_y, 3);
`ifdef CV_BG_FETCH_OVERRUN_EN
      check("t4_overrun", o_overrun, 1);
`else
      check("t4_overrun", o_overrun, 0);
`endif

      // reset mid-line with a full FIFO
      o_ready = 0;
      start_line(0, 10'h000, 10'h000);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("t5_full_valid", o_valid, 1);
      check("t5_full_no_issue", t_ren, 0);
      @(posedge clk); #1 reset = 1;
      exp_q.delete();
      @(negedge clk);
      check("t5_o_valid", o_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_t_ren", t_ren, 0);
      check("t5_overrun", o_overrun, 0);
      @(posedge clk); #1 reset = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t5_stay_idle", t_ren, 0);
      @(posedge clk); #1;

      // TILES=1 instance
      o_ready = 1;
      start_line(0, 10'h000, 10'h000);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("t6_busy", busy1, k <= 3);
         check("t6_t_ren", t_ren1, k == 1);
         check("t6_o_valid", o_valid1, k == 3);
         if (k == 3) begin
            check("t6_o_last", o_last1, 1);
            check("t6_o_tile", o_tile1, tval(addr_of(0, 10'h000, 10'h000, 0)));
         end
         @(posedge clk); #1;
      end
      wait_idle();
      check("t6_main_words", popped, T);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
